// File: rtl/alu_operand_rf.sv
// rtl/alu_operand_rf.sv - ALU operand register file with buffered write-back queue and read bypass
module alu_operand_rf #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int WQ_DEPTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_WIDTH-1:0]         raddr1,
  input  logic [ADDR_WIDTH-1:0]         raddr2,
  output logic [DATA_WIDTH-1:0]         rdata1,
  output logic [DATA_WIDTH-1:0]         rdata2,
  input  logic                          wb_valid,
  output logic                          wb_ready,
  input  logic [ADDR_WIDTH-1:0]         wb_addr,
  input  logic [DATA_WIDTH-1:0]         wb_data,
  input  logic [2:0]                    wb_flags,
  input  logic                          drain_stall,
  output logic [2:0]                    flags_q,
  output logic [$clog2(WQ_DEPTH):0]     wq_count,
  output logic                          wq_busy
);

  localparam int PW   = $clog2(WQ_DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs    [NREG];
  logic [ADDR_WIDTH-1:0] q_addr  [WQ_DEPTH];
  logic [DATA_WIDTH-1:0] q_data  [WQ_DEPTH];
  logic [2:0]            q_flags [WQ_DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;
  logic                  enq;
  logic                  pop;

  // Ready depends on registered occupancy only, so a full queue with an
  // active drain still refuses this cycle and opens up on the next one.
  assign wb_ready = (count != CW'(WQ_DEPTH));
  // Writes to register 0 complete the handshake but are dropped here.
  assign enq      = wb_valid & wb_ready & (wb_addr != '0);
  assign pop      = (count != '0) & ~drain_stall;
  assign wq_count = count;
  assign wq_busy  = (count != '0);

  // Walk queued entries oldest to youngest so the youngest match wins;
  // register 0 is forced to zero last.
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] v;
    logic [PW-1:0]         idx;
    v = regs[a];
    for (int i = 0; i < WQ_DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (q_addr[idx] == a)) begin
        v = q_data[idx];
      end
    end
    if (a == '0) begin
      v = '0;
    end
    return v;
  endfunction

  assign rdata1 = read_port(raddr1);
  assign rdata2 = read_port(raddr2);

  // Queue pointers and occupancy; reset discards any pending entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue payload storage; slots outside head..count are never observed.
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      q_addr[tail]  <= wb_addr;
      q_data[tail]  <= wb_data;
      q_flags[tail] <= wb_flags;
    end
  end

  // Architectural array: the oldest entry retires here when not stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else if (pop) begin
      regs[q_addr[head]] <= q_data[head];
    end
  end

  // Flags follow the entry that retires into the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (pop) begin
      flags_q <= q_flags[head];
    end
  end

endmodule

// File: tb/tb_alu_operand_rf.sv
// tb/tb_alu_operand_rf.sv - randomized and directed self-checking bench for alu_operand_rf
module tb_alu_operand_rf;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  raddr1, raddr2, wb_addr;
  logic [31:0] rdata1, rdata2, wb_data;
  logic        wb_valid, wb_ready, drain_stall, wq_busy;
  logic [2:0]  wb_flags, flags_q;
  logic [1:0]  wq_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic [2:0]  f;
  } ent_t;

  logic [31:0] m_rf [32];
  logic [2:0]  m_flags;
  ent_t        mq[$];

  alu_operand_rf #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_flags(wb_flags),
    .drain_stall(drain_stall), .flags_q(flags_q), .wq_count(wq_count), .wq_busy(wq_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].a == a) return mq[i].d;
    end
    return m_rf[a];
  endfunction

  function automatic logic m_ready();
    return mq.size() < DEPTH;
  endfunction

  task automatic model_step();
    logic can_push;
    if (rst) begin
      for (int r = 0; r < 32; r++) m_rf[r] = 32'd0;
      mq.delete();
      m_flags = 3'd0;
    end else begin
      can_push = m_ready();
      if (mq.size() > 0 && !drain_stall) begin
        m_rf[mq[0].a] = mq[0].d;
        m_flags = mq[0].f;
        mq.delete(0);
      end
      if (wb_valid && can_push && wb_addr != 5'd0) mq.push_back('{wb_addr, wb_data, wb_flags});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; wb_flags = 3'd0; drain_stall = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); tick(); rst = 1'b0;
    #1;
    n_checks++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", wb_ready); end
    n_checks++; if (wq_count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", wq_count); end
    n_checks++; if (flags_q !== 3'd0) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", flags_q); end
    n_checks++; if (wq_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", wq_busy); end
    for (int r = 1; r < 32; r++) begin
      raddr1 = 5'(r); raddr2 = 5'(32 - r);
      #1;
      n_checks++; if (rdata1 !== 32'd0) begin n_fail++; $display("FAIL reset_rd1 r%0d: got %h expected 0", r, rdata1); end
      n_checks++; if (rdata2 !== 32'd0) begin n_fail++; $display("FAIL reset_rd2 r%0d: got %h expected 0", 32 - r, rdata2); end
      tick();
    end
  endtask

  task automatic test_stall_push();
    drain_stall = 1'b1; wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_00FF; wb_flags = 3'b000;
    tick();
    wb_valid = 1'b0; raddr1 = 5'd5;
    #1;
    n_checks++; if (rdata1 !== 32'h0000_00FF) begin n_fail++; $display("FAIL stall_bypass: got %h expected 000000ff", rdata1); end
    n_checks++; if (wq_count !== 2'd1) begin n_fail++; $display("FAIL stall_count: got %0d expected 1", wq_count); end
    drain_stall = 1'b0;
    tick();
    #1;
    n_checks++; if (wq_count !== 2'd0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", wq_count); end
    n_checks++; if (rdata1 !== 32'h0000_00FF) begin n_fail++; $display("FAIL drain_read: got %h expected 000000ff", rdata1); end
    n_checks++; if (flags_q !== 3'd0) begin n_fail++; $display("FAIL drain_flags: got %b expected 000", flags_q); end
  endtask

  task automatic test_full_hold();
    drain_stall = 1'b1; wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h1111_1111; wb_flags = 3'b001;
    tick();
    wb_data = 32'h2222_2222; wb_flags = 3'b010;
    tick();
    wb_addr = 5'd9; wb_data = 32'h3333_3333; wb_flags = 3'b101; raddr2 = 5'd7; raddr1 = 5'd9;
    #1;
    n_checks++; if (wq_count !== 2'd2) begin n_fail++; $display("FAIL full_count: got %0d expected 2", wq_count); end
    n_checks++; if (wb_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", wb_ready); end
    n_checks++; if (rdata2 !== 32'h2222_2222) begin n_fail++; $display("FAIL full_youngest: got %h expected 22222222", rdata2); end
    tick(); tick();
    #1;
    n_checks++; if (wq_count !== 2'd2) begin n_fail++; $display("FAIL held_count: got %0d expected 2", wq_count); end
    n_checks++; if (rdata1 !== 32'd0) begin n_fail++; $display("FAIL held_not_accepted: got %h expected 0", rdata1); end
    drain_stall = 1'b0;
    tick();
    #1;
    n_checks++; if (wb_ready !== 1'b1 || wq_count !== 2'd1) begin n_fail++; $display("FAIL release_pop_only: got ready=%b count=%0d expected ready=1 count=1", wb_ready, wq_count); end
    n_checks++; if (flags_q !== 3'b001) begin n_fail++; $display("FAIL release_flags: got %b expected 001", flags_q); end
    tick();
    #1;
    n_checks++; if (wq_count !== 2'd1) begin n_fail++; $display("FAIL pushpop_count: got %0d expected 1", wq_count); end
    n_checks++; if (rdata1 !== 32'h3333_3333) begin n_fail++; $display("FAIL third_visible: got %h expected 33333333", rdata1); end
    wb_valid = 1'b0;
    tick();
    #1;
    n_checks++; if (rdata2 !== 32'h2222_2222) begin n_fail++; $display("FAIL array_r7: got %h expected 22222222", rdata2); end
    n_checks++; if (flags_q !== 3'b101 || wq_busy !== 1'b0) begin n_fail++; $display("FAIL final_flags_busy: got %b/%b expected 101/0", flags_q, wq_busy); end
  endtask

  task automatic test_r0();
    logic [2:0] exp_flags;
    exp_flags = m_flags;
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF; wb_flags = 3'b111; raddr1 = 5'd0;
    #1;
    n_checks++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL r0_ready: got %b expected 1", wb_ready); end
    tick();
    wb_valid = 1'b0;
    #1;
    n_checks++; if (wq_count !== 2'd0) begin n_fail++; $display("FAIL r0_count: got %0d expected 0", wq_count); end
    n_checks++; if (rdata1 !== 32'd0) begin n_fail++; $display("FAIL r0_read: got %h expected 0", rdata1); end
    tick();
    #1;
    n_checks++; if (flags_q !== exp_flags) begin n_fail++; $display("FAIL r0_flags: got %b expected %b", flags_q, exp_flags); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] last_f;
    drain_stall = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      wb_valid = 1'b1; wb_addr = 5'(i); wb_data = 32'(i * 16); wb_flags = 3'($urandom_range(0, 7));
      last_f = wb_flags;
      tick();
      #1;
      n_checks++; if (wq_count > 2'd1 || wq_count !== 2'(mq.size())) begin n_fail++; $display("FAIL stream_count i=%0d: got %0d expected %0d", i, wq_count, mq.size()); end
    end
    wb_valid = 1'b0;
    tick();
    #1;
    n_checks++; if (flags_q !== last_f) begin n_fail++; $display("FAIL stream_flags: got %b expected %b", flags_q, last_f); end
    for (int i = 1; i <= 8; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(9 - i);
      #1;
      n_checks++; if (rdata1 !== 32'(i * 16)) begin n_fail++; $display("FAIL stream_rd1 r%0d: got %h expected %h", i, rdata1, 32'(i * 16)); end
      n_checks++; if (rdata2 !== 32'((9 - i) * 16)) begin n_fail++; $display("FAIL stream_rd2 r%0d: got %h expected %h", 9 - i, rdata2, 32'((9 - i) * 16)); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst         = ($urandom_range(0, 59) == 0);
      wb_valid    = $urandom_range(0, 1);
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      wb_flags    = 3'($urandom_range(0, 7));
      drain_stall = ($urandom_range(0, 9) < 4);
      raddr1      = 5'($urandom_range(0, 7));
      raddr2      = 5'($urandom_range(0, 7));
      #1;
      n_checks++; if (rdata1 !== m_read(raddr1)) begin n_fail++; $display("FAIL rand_rd1 c%0d a%0d: got %h expected %h", c, raddr1, rdata1, m_read(raddr1)); end
      n_checks++; if (rdata2 !== m_read(raddr2)) begin n_fail++; $display("FAIL rand_rd2 c%0d a%0d: got %h expected %h", c, raddr2, rdata2, m_read(raddr2)); end
      n_checks++; if (wb_ready !== m_ready()) begin n_fail++; $display("FAIL rand_ready c%0d: got %b expected %b", c, wb_ready, m_ready()); end
      n_checks++; if (wq_count !== 2'(mq.size()) || wq_busy !== (mq.size() != 0)) begin n_fail++; $display("FAIL rand_count c%0d: got %0d/%b expected %0d", c, wq_count, wq_busy, mq.size()); end
      n_checks++; if (flags_q !== m_flags) begin n_fail++; $display("FAIL rand_flags c%0d: got %b expected %b", c, flags_q, m_flags); end
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_full();
    idle(); tick(); tick(); tick();
    drain_stall = 1'b1; wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hAAAA_AAAA; wb_flags = 3'b110;
    tick();
    wb_addr = 5'd4; wb_data = 32'hBBBB_BBBB;
    tick();
    #1;
    n_checks++; if (wq_count !== 2'd2) begin n_fail++; $display("FAIL prereset_count: got %0d expected 2", wq_count); end
    rst = 1'b1; drain_stall = 1'b0; wb_addr = 5'd5;
    tick();
    rst = 1'b0; wb_valid = 1'b0; raddr1 = 5'd3; raddr2 = 5'd4;
    #1;
    n_checks++; if (wq_count !== 2'd0 || wq_busy !== 1'b0) begin n_fail++; $display("FAIL rst_full_count: got %0d/%b expected 0/0", wq_count, wq_busy); end
    n_checks++; if (wb_ready !== 1'b1 || flags_q !== 3'd0) begin n_fail++; $display("FAIL rst_full_ready_flags: got %b/%b expected 1/000", wb_ready, flags_q); end
    tick(); tick();
    #1;
    n_checks++; if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin n_fail++; $display("FAIL rst_full_lost: got %h/%h expected 0/0", rdata1, rdata2); end
    raddr1 = 5'd5;
    #1;
    n_checks++; if (rdata1 !== 32'd0) begin n_fail++; $display("FAIL rst_priority_push: got %h expected 0", rdata1); end
  endtask

  initial begin
    rst = 1'b1; raddr1 = 5'd0; raddr2 = 5'd0; idle();
    @(negedge clk);
    test_reset();
    test_stall_push();
    test_full_hold();
    test_r0();
    test_back_to_back();
    test_random();
    test_reset_full();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_operand_rf.md
Name: alu_operand_rf

Overview:
- Register file on the far side of the ALU operand/result interface.
- Sources A/B operands through two combinational read ports and sinks ALU results plus flags through a valid/ready write-back port.
- Accepted write-backs are buffered in a small in-order write queue and drained into the array one entry per cycle.
- Reads see pending (queued) values via youngest-match bypass.

Parameters:
- DATA_WIDTH, 32, register and operand width.
- ADDR_WIDTH, 5, register address width (2^ADDR_WIDTH registers).
- WQ_DEPTH, 2, write-queue entries (power of two, >= 2).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- raddr1  input  ADDR_WIDTH  read port 1 address (drives ALU A).
- raddr2  input  ADDR_WIDTH  read port 2 address (drives ALU B).
- rdata1  output  DATA_WIDTH  read port 1 data, combinational.
- rdata2  output  DATA_WIDTH  read port 2 data, combinational.
- wb_valid  input  1  write-back request.
- wb_ready  output  1  write-back accept.
- wb_addr  input  ADDR_WIDTH  destination register.
- wb_data  input  DATA_WIDTH  ALU Result.
- wb_flags  input  3  {Overflow, CarryOut, Zero} from the ALU.
- drain_stall  input  1  1 = hold the queue, no array write this cycle.
- flags_q  output  3  flags of the last drained entry.
- wq_count  output  $clog2(WQ_DEPTH)+1  queued entries.
- wq_busy  output  1  wq_count != 0.

Behaviour:
- Reset (rst=1 at edge):
  - All registers cleared to 0.
  - Queue emptied; pending entries are discarded, never written.
  - flags_q=0, wq_count=0, wq_busy=0, wb_ready=1 in the following cycle.
  - Reset has priority over push and drain in the same cycle.
- Handshake:
  - wb_ready = (wq_count != WQ_DEPTH); registered state only, no combinational path from wb_valid.
  - A transfer occurs when wb_valid & wb_ready at the edge.
  - wb_addr == 0 with a transfer: accepted (handshake completes), nothing enqueued, flags_q unchanged.
- Drain:
  - If queue non-empty and drain_stall=0, the oldest entry writes its data to array[addr] and its flags to flags_q at the edge, then is popped.
  - Drain rate is exactly one entry per cycle.
- Simultaneous push and pop:
  - Count unchanged.
  - Allowed only when ready was 1 (not full), because ready depends on count only.
  - When full with drain active, ready stays 0 that cycle and rises next cycle.
- Queue storage:
  - Circular buffer with head/tail pointers that wrap modulo WQ_DEPTH.
  - Count tracks full vs empty; a full queue keeps head == tail with count = WQ_DEPTH.
- Read path, each port independently:
  - addr 0 -> 0.
  - Otherwise, the youngest queued entry with a matching address supplies the data.
  - Otherwise the array supplies the data.
  - A value being drained this cycle is still read from the queue; from the next cycle it is read from the array. There is no glitch window.
  - Same-cycle wb_data is NOT forwarded to rdata; it becomes visible the cycle after acceptance.
- Register 0:
  - Never written, always reads 0.
- Widths:
  - Data is stored verbatim; there is no arithmetic in this block.
  - Flags are stored verbatim.
- Latency:
  - Accepted write is readable 1 cycle after the accepting edge.
  - Architectural (array) update occurs at least 1 cycle after acceptance, or later under stall.

Test Plan:
- Reset then read r1..r31 -> all 0; wb_ready=1, wq_count=0, flags_q=0.
- Push r5=0x0000_00FF with flags 3'b000 while drain_stall=1 -> next cycle rdata1(raddr1=5)=0x0000_00FF from queue, wq_count=1; release stall -> array[5]=0xFF, flags_q=0, wq_count=0, read unchanged.
- drain_stall=1, push r7=0x1111_1111 then r7=0x2222_2222 -> wq_count=2, wb_ready=0, rdata2(7)=0x2222_2222.
  - A third push with wb_valid=1 is held until the stall is released.
  - After drain, array[7]=0x2222_2222.
- Push r0=0xDEAD_BEEF with flags 3'b111 -> accepted, wq_count stays 0, rdata1(0)=0, flags_q unchanged.
- Continuous pushes, one per cycle with drain_stall=0, to r1..r8 with data i*0x10 -> wq_count never exceeds 1, pointers wrap, r1..r8 read 0x10..0x80, flags_q equals the last entry's flags.
- Full queue (stall), assert rst for one cycle -> wq_count=0, pending entries lost, targeted registers read 0.
